dpi_object_arbiter: RTL and testbench

DPI_OBJECT_ARBITER -- requirements
Module: dpi_object_arbiter

---
 rtl/dpi_object_arbiter.sv | 141 ++++++++++++++
 tb/tb_dpi_object_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpi_object_arbiter.sv
// Purpose: round-robin merge of NUM_CH object producers into one shared FIFO drained by the DPI side.
// Latency: an object accepted on edge k is visible at the output (first-word-fall-through) from cycle k+1.
// Backpressure: in_ready is withheld while the queue is full or flush is high; there is no bypass at full.
// Optional: define DPI_OBJ_TSTAMP_EN to add a free-running cycle counter, per-entry capture and out_tstamp.
module dpi_object_arbiter #(
  parameter int NUM_CH = 4,
  parameter int TAG_W  = 8,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16
) (
  input  logic                        PCLK,
  input  logic                        PRESETn,
  input  logic                        flush,
  input  logic [NUM_CH-1:0]           in_valid,
  output logic [NUM_CH-1:0]           in_ready,
  input  logic [NUM_CH*TAG_W-1:0]     in_tag,
  input  logic [NUM_CH*DATA_W-1:0]    in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(NUM_CH)-1:0]   out_ch,
  output logic [TAG_W-1:0]            out_tag,
  output logic [DATA_W-1:0]           out_data,
  output logic [$clog2(DEPTH):0]      level
`ifdef DPI_OBJ_TSTAMP_EN
  ,
  output logic [31:0]                 out_tstamp
`endif
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;

  logic [CH_W-1:0] rr_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   cnt;

  logic            gnt_vld;
  logic [CH_W-1:0] gnt_idx;
  logic            full;
  logic            empty;
  logic            enq;
  logic            deq;

  logic [CH_W-1:0]   mem_ch   [DEPTH];
  logic [TAG_W-1:0]  mem_tag  [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  // Channel index reached by stepping k slots up from base, wrapping at NUM_CH (NUM_CH need not be a power of two).
  function automatic logic [CH_W-1:0] rr_slot(input logic [CH_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CH_W'(s);
  endfunction

  assign full  = (cnt == LW'(DEPTH));
  assign empty = (cnt == '0);
  // Reset gating keeps in_ready low while PRESETn is asserted even if sources are offering.
  assign enq   = gnt_vld && !full && !flush && PRESETn;
  assign deq   = !empty && out_ready && !flush;

  // Round-robin search: first offering channel at or above rr_ptr, with wrap-around.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!gnt_vld && in_valid[rr_slot(rr_ptr, k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = rr_slot(rr_ptr, k);
      end
    end
  end

  // One-hot acceptance for the granted channel only.
  always_comb begin
    in_ready = '0;
    if (enq) in_ready[gnt_idx] = 1'b1;
  end

  // Entry storage carries no reset; occupancy and pointers alone decide what is visible.
  always_ff @(posedge PCLK) begin
    if (enq) begin
      mem_ch[wr_ptr]   <= gnt_idx;
      mem_tag[wr_ptr]  <= in_tag[gnt_idx*TAG_W +: TAG_W];
      mem_data[wr_ptr] <= in_data[gnt_idx*DATA_W +: DATA_W];
    end
  end

  // Pointer, occupancy and round-robin state; flush clears everything and counts no transfer.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign level     = cnt;
  assign out_valid = !empty;
  assign out_ch    = empty ? '0 : mem_ch[rd_ptr];
  assign out_tag   = empty ? '0 : mem_tag[rd_ptr];
  assign out_data  = empty ? '0 : mem_data[rd_ptr];

`ifdef DPI_OBJ_TSTAMP_EN
  logic [31:0] cyc_cnt;
  logic [31:0] mem_ts [DEPTH];

  // Free-running cycle counter, wraps naturally at 2^32.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) cyc_cnt <= '0;
    else          cyc_cnt <= cyc_cnt + 32'd1;
  end

  // Capture the counter value present on the enqueue edge.
  always_ff @(posedge PCLK) begin
    if (enq) mem_ts[wr_ptr] <= cyc_cnt;
  end

  assign out_tstamp = empty ? '0 : mem_ts[rd_ptr];
`endif

endmodule

// File: tb/tb_dpi_object_arbiter.sv
module tb_dpi_object_arbiter;

  localparam int NUM_CH = 4;
  localparam int TAG_W  = 8;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 16;

  logic                     PCLK = 1'b0;
  logic                     PRESETn;
  logic                     flush;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic [NUM_CH*TAG_W-1:0]  in_tag;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [1:0]               out_ch;
  logic [TAG_W-1:0]         out_tag;
  logic [DATA_W-1:0]        out_data;
  logic [4:0]               level;
`ifdef DPI_OBJ_TSTAMP_EN
  logic [31:0]              out_tstamp;
`endif

  dpi_object_arbiter #(
    .NUM_CH(NUM_CH), .TAG_W(TAG_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_tag(out_tag), .out_data(out_data), .level(level)
`ifdef DPI_OBJ_TSTAMP_EN
    , .out_tstamp(out_tstamp)
`endif
  );

  always #5 PCLK = ~PCLK;

  // Reference model: queue of objects, round-robin pointer, pending offers per source.
  typedef struct {
    int          ch;
    logic [7:0]  tag;
    logic [63:0] data;
    logic [31:0] ts;
  } ent_t;

  ent_t        q[$];
  int          rr;
  bit          pend_v   [NUM_CH];
  logic [7:0]  pend_tag [NUM_CH];
  logic [63:0] pend_dat [NUM_CH];
  int          last_acc;
  int          n_asserts = 0;
  int          n_fail    = 0;
  logic [31:0] m_cyc;
  int          fair_cnt [NUM_CH];
  int          offered, accepted;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) m_cyc <= 32'd0;
    else          m_cyc <= m_cyc + 32'd1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input int ch);
    pend_v[ch]   = 1'b1;
    pend_tag[ch] = 8'($urandom);
    pend_dat[ch] = {$urandom, $urandom};
  endtask

  task automatic clear_offers();
    for (int i = 0; i < NUM_CH; i++) pend_v[i] = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    rr = 0;
    clear_offers();
  endtask

  // One clock cycle: drive at negedge, check outputs against the model, advance model, cross posedge.
  task automatic cycle(input logic ordy, input logic fl, input bit refill);
    int            g;
    logic [3:0]    exp_rdy;
    int            e_ch;
    logic [7:0]    e_tag;
    logic [63:0]   e_dat;
    logic [31:0]   e_ts;
    ent_t          e;
    for (int i = 0; i < NUM_CH; i++) begin
      in_valid[i]               = pend_v[i];
      in_tag[i*TAG_W +: TAG_W]  = pend_tag[i];
      in_data[i*DATA_W +: DATA_W] = pend_dat[i];
    end
    out_ready = ordy;
    flush     = fl;
    #1;
    g = -1;
    for (int k = 0; k < NUM_CH; k++)
      if (g < 0 && pend_v[(rr + k) % NUM_CH]) g = (rr + k) % NUM_CH;
    exp_rdy = 4'b0;
    if (g >= 0 && q.size() < DEPTH && !fl) exp_rdy[g] = 1'b1;
    e_ch = 0; e_tag = '0; e_dat = '0; e_ts = '0;
    if (q.size() > 0) begin
      e_ch = q[0].ch; e_tag = q[0].tag; e_dat = q[0].data; e_ts = q[0].ts;
    end
    chk("in_ready",  in_ready, exp_rdy);
    chk("out_valid", out_valid, q.size() > 0);
    chk("level",     level, 64'(q.size()));
    chk("out_ch",    out_ch, 64'(e_ch));
    chk("out_tag",   out_tag, e_tag);
    chk("out_data",  out_data, e_dat);
`ifdef DPI_OBJ_TSTAMP_EN
    chk("out_tstamp", out_tstamp, e_ts);
`endif
    last_acc = -1;
    if (fl) begin
      q.delete();
      rr = 0;
    end else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (exp_rdy != 4'b0) begin
        e.ch = g; e.tag = pend_tag[g]; e.data = pend_dat[g]; e.ts = m_cyc;
        q.push_back(e);
        rr = (g + 1) % NUM_CH;
        pend_v[g] = 1'b0;
        last_acc = g;
        if (refill) offer(g);
      end
    end
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  task automatic drain();
    clear_offers();
    for (int i = 0; i < 60 && q.size() > 0; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("drain_level", level, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESETn = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = '0; in_tag = '0; in_data = '0;
    model_reset();
    for (int i = 0; i < NUM_CH; i++) begin pend_tag[i] = '0; pend_dat[i] = '0; end

    // Reset state with all channels offering
    #2 PRESETn = 1'b0;
    in_valid = 4'hF;
    #1;
    chk("rst_in_ready",  in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level",     level, 0);
    chk("rst_out_ch",    out_ch, 0);
    chk("rst_out_tag",   out_tag, 0);
    chk("rst_out_data",  out_data, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;

    // Single object from channel 2
    offer(2);
    pend_tag[2] = 8'h11;
    pend_dat[2] = 64'hCAFE;
    cycle(1'b0, 1'b0, 1'b0);
    chk("single_acc_ch",   last_acc, 2);
    chk("single_out_vld",  out_valid, 1);
    chk("single_out_ch",   out_ch, 2);
    chk("single_out_tag",  out_tag, 8'h11);
    chk("single_out_data", out_data, 64'hCAFE);
    chk("single_level",    level, 1);
    drain();

    // Fairness: all four channels continuously offering
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < NUM_CH; i++) begin offer(i); fair_cnt[i] = 0; end
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 1'b0, 1'b1);
      chk("fair_grant", last_acc, k % NUM_CH);
      if (last_acc >= 0) fair_cnt[last_acc]++;
    end
    for (int i = 0; i < NUM_CH; i++) chk("fair_count", fair_cnt[i], 2);
    drain();

    // Full: channel 0 streams with the drain stalled
    cycle(1'b0, 1'b1, 1'b0);
    offer(0);
    for (int k = 0; k < DEPTH; k++) cycle(1'b0, 1'b0, 1'b1);
    chk("full_level", level, 16);
    chk("full_in_ready", in_ready, 0);
    cycle(1'b1, 1'b0, 1'b1);
    chk("full_after_pop_rdy", in_ready, 4'b0001);
    chk("full_after_pop_lvl", level, 15);
    drain();

    // Wrap: 40 random objects, random drain
    cycle(1'b0, 1'b1, 1'b0);
    offered = 0; accepted = 0;
    for (int c = 0; c < 3000; c++) begin
      if (offered == 40 && accepted == 40 && q.size() == 0) break;
      for (int i = 0; i < NUM_CH; i++)
        if (!pend_v[i] && offered < 40 && $urandom_range(0, 1) == 1) begin
          offer(i);
          offered++;
        end
      cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (last_acc >= 0) accepted++;
      chk("wrap_level_bound", level <= 5'd16, 1);
    end
    chk("wrap_accepted", accepted, 40);
    chk("wrap_level_end", level, 0);

    // Asynchronous reset mid-burst at level 7
    cycle(1'b0, 1'b1, 1'b0);
    offer(1);
    for (int k = 0; k < 7; k++) cycle(1'b0, 1'b0, 1'b1);
    chk("pre_reset_level", level, 7);
    PRESETn = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_level",     level, 0);
    chk("async_rst_in_ready",  in_ready, 0);
    model_reset();
    @(negedge PCLK);
    PRESETn = 1'b1;
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 1'b0);
    offer(3);
    pend_tag[3] = 8'hA5;
    cycle(1'b0, 1'b0, 1'b0);
    chk("post_rst_out_ch",  out_ch, 3);
    chk("post_rst_out_tag", out_tag, 8'hA5);
    chk("post_rst_level",   level, 1);
`ifdef DPI_OBJ_TSTAMP_EN
    chk("tstamp_cycle10", out_tstamp, 32'd10);
`endif
    drain();

    // Flush at level 5
    offer(0);
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 1'b1);
    chk("pre_flush_level", level, 5);
    cycle(1'b1, 1'b1, 1'b0);
    chk("flush_level",     level, 0);
    chk("flush_out_valid", out_valid, 0);
    drain();

`ifdef DPI_OBJ_TSTAMP_EN
    // Counter wrap from all-ones to zero
    force dut.cyc_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cyc_cnt;
    chk("tstamp_forced", dut.cyc_cnt, 32'hFFFF_FFFF);
    @(posedge PCLK);
    #1;
    chk("tstamp_wrap", dut.cyc_cnt, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
